// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU: opcode constants
//               and controller state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Opcodes
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_ROL  = 4'h6;
   localparam logic [3:0] OP_ROR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_NOR  = 4'hB;
   localparam logic [3:0] OP_NAND = 4'hC;
   localparam logic [3:0] OP_XNOR = 4'hD;
   localparam logic [3:0] OP_GT   = 4'hE;
   localparam logic [3:0] OP_EQ   = 4'hF;

endpackage
`default_nettype wire

// File: rtl/alu_div.sv
`default_nettype none
// ============================================================================
// Module      : alu_div
// Description : Restoring unsigned divider, one quotient bit per clock.
//               The first iteration is performed on the go edge, so the
//               final quotient/remainder are registered WIDTH-1 clocks
//               later and fin pulses for one cycle at that point.
// Ports       : clk, rst (async active-low), go (load + first step),
//               dividend, divisor, quotient, remainder, fin (result valid)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             fin
);

   localparam int            CW          = $clog2(WIDTH);
   // Iterations still to run after the one done on the go edge
   localparam logic [CW-1:0] c_ITER_INIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_ITER_LAST = CW'(1);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic [CW-1:0]    r_cnt;
   logic             r_run;
   logic             r_fin;

   logic [WIDTH-1:0] w_rem_in;
   logic [WIDTH-1:0] w_quo_in;
   logic [WIDTH-1:0] w_dvs_in;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_fits;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;

   // On go the step operates directly on the incoming operands
   assign w_rem_in  = go ? '0       : r_rem;
   assign w_quo_in  = go ? dividend : r_quo;
   assign w_dvs_in  = go ? divisor  : r_dvs;

   // Shift next dividend bit into the partial remainder, trial subtract
   assign w_shift   = {w_rem_in, w_quo_in[WIDTH-1]};
   assign w_diff    = w_shift - {1'b0, w_dvs_in};
   assign w_fits    = ~w_diff[WIDTH];
   assign w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {w_quo_in[WIDTH-2:0], w_fits};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
         r_fin <= 1'b0;
      end else begin
         r_fin <= 1'b0;
         if (go) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_dvs <= divisor;
            r_cnt <= c_ITER_INIT;
            r_run <= 1'b1;
         end else if (r_run) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == c_ITER_LAST) begin
               r_run <= 1'b0;
               r_fin <= 1'b1;
            end
         end
      end
   end

   assign quotient  = r_quo;
   assign remainder = r_rem;
   assign fin       = r_fin;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU. Single-cycle operations are evaluated
//               combinationally from the operands presented with start and
//               registered on the start edge; division runs in alu_div.
// Ports       : clk, rst (async active-low), start, op[3:0], a, b,
//               result[2*WIDTH-1:0], carry, ovf, zero, dz, busy, done
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result,
   output logic               carry,
   output logic               ovf,
   output logic               zero,
   output logic               dz,
   output logic               busy,
   output logic               done
);

   localparam logic [WIDTH-1:0] c_ZERO_W = '0;

   state_t             r_state;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_sub;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_res;
   logic               w_carry;
   logic               w_ovf;
   logic               w_dz;
   logic               w_div_go;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               w_fin;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_sub  = {1'b0, a} - {1'b0, b};
   assign w_prod = {c_ZERO_W, a} * {c_ZERO_W, b};

   // Only a divide with a non-zero divisor goes multi-cycle
   assign w_div_go = (r_state == ST_IDLE) && start && (op == OP_DIV) && (b != c_ZERO_W);

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_dz    = 1'b0;
      case (op)
         OP_ADD: begin
            w_res   = {c_ZERO_W, w_sum[WIDTH-1:0]};
            w_carry = w_sum[WIDTH];
            w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res   = {c_ZERO_W, w_sub[WIDTH-1:0]};
            w_carry = w_sub[WIDTH];
            w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL: begin
            w_res   = w_prod;
            w_ovf   = (w_prod[2*WIDTH-1:WIDTH] != c_ZERO_W);
         end
         // Reached only with b==0; the b!=0 case is taken by the divider
         OP_DIV: begin
            w_res   = {a, {WIDTH{1'b1}}};
            w_dz    = 1'b1;
         end
         OP_SHL: begin
            w_res   = {c_ZERO_W, a[WIDTH-2:0], 1'b0};
            w_carry = a[WIDTH-1];
         end
         OP_SHR: begin
            w_res   = {c_ZERO_W, 1'b0, a[WIDTH-1:1]};
            w_carry = a[0];
         end
         OP_ROL:  w_res = {c_ZERO_W, a[WIDTH-2:0], a[WIDTH-1]};
         OP_ROR:  w_res = {c_ZERO_W, a[0], a[WIDTH-1:1]};
         OP_AND:  w_res = {c_ZERO_W, a & b};
         OP_OR:   w_res = {c_ZERO_W, a | b};
         OP_XOR:  w_res = {c_ZERO_W, a ^ b};
         OP_NOR:  w_res = {c_ZERO_W, ~(a | b)};
         OP_NAND: w_res = {c_ZERO_W, ~(a & b)};
         OP_XNOR: w_res = {c_ZERO_W, ~(a ^ b)};
         OP_GT:   w_res = {{(2*WIDTH-1){1'b0}}, (a > b)};
         OP_EQ:   w_res = {{(2*WIDTH-1){1'b0}}, (a == b)};
      endcase
   end

   alu_div #(
      .WIDTH     (WIDTH)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .go        (w_div_go),
      .dividend  (a),
      .divisor   (b),
      .quotient  (w_quo),
      .remainder (w_rem),
      .fin       (w_fin)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         result  <= '0;
         carry   <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b1;
         dz      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (w_div_go) begin
                     r_state <= ST_DIV;
                  end else begin
                     r_state <= ST_DONE;
                     done    <= 1'b1;
                     result  <= w_res;
                     carry   <= w_carry;
                     ovf     <= w_ovf;
                     dz      <= w_dz;
                     zero    <= (w_res[WIDTH-1:0] == c_ZERO_W);
                  end
               end
            end
            ST_DIV: begin
               if (w_fin) begin
                  r_state <= ST_DONE;
                  done    <= 1'b1;
                  result  <= {w_rem, w_quo};
                  carry   <= 1'b0;
                  ovf     <= 1'b0;
                  dz      <= 1'b0;
                  zero    <= (w_quo == c_ZERO_W);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=8). Table of
//               operations with hand-derived expected results, a scoreboard
//               queue checked whenever done pulses, plus hand-written
//               sequences for division busy/done timing and mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   localparam int WIDTH = 8;

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic        c;
      logic        v;
      logic        z;
      logic        d;
      int          lat;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] result;
   logic        carry;
   logic        ovf;
   logic        zero;
   logic        dz;
   logic        busy;
   logic        done;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   alu_seq #(
      .WIDTH  (WIDTH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .result (result),
      .carry  (carry),
      .ovf    (ovf),
      .zero   (zero),
      .dz     (dz),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                               input logic [15:0] r, input logic c, input logic v,
                               input logic z, input logic d, input int lat);
      vec_t t;
      t.op = o; t.a = x; t.b = y; t.res = r;
      t.c = c; t.v = v; t.z = z; t.d = d; t.lat = lat;
      return t;
   endfunction

   // Scoreboard: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (rst && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(result), 64'hDEAD_BEEF);
         end else begin
            vec_t e;
            string tag;
            e = exp_q.pop_front();
            tag = $sformatf("op%0h_a%0h_b%0h", e.op, e.a, e.b);
            check({tag, "_result"}, 64'(result), 64'(e.res));
            check({tag, "_carry"},  64'(carry),  64'(e.c));
            check({tag, "_ovf"},    64'(ovf),    64'(e.v));
            check({tag, "_zero"},   64'(zero),   64'(e.z));
            check({tag, "_dz"},     64'(dz),     64'(e.d));
            check({tag, "_busy"},   64'(busy),   64'd1);
         end
      end
   end

   // Called at a negedge with the DUT idle; drives one operation and checks latency
   task automatic run_vec(input vec_t v);
      int lat;
      op    = v.op;
      a     = v.a;
      b     = v.b;
      start = 1'b1;
      exp_q.push_back(v);
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(negedge clk);
         if (done) lat = c;
      end
      check($sformatf("op%0h_a%0h_b%0h_latency", v.op, v.a, v.b), 64'(lat), 64'(v.lat));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int busy_cnt;
      int done_cnt;
      int done_at;

      rst   = 1'b0;
      start = 1'b0;
      op    = 4'h0;
      a     = 8'h00;
      b     = 8'h00;

      //         op    a      b      result   c     v     z     d     lat
      tbl.push_back(mk(4'h0, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h1, 8'd3,   8'd5,   16'h00FE, 1'b1, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h1, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1));
      tbl.push_back(mk(4'h1, 8'h80,  8'h01,  16'h007F, 1'b0, 1'b1, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h0, 8'h7F,  8'h01,  16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h2, 8'd15,  8'd17,  16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h2, 8'd16,  8'd16,  16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 1));
      tbl.push_back(mk(4'h2, 8'hFF,  8'hFF,  16'hFE01, 1'b0, 1'b1, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h3, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 1'b0, 1'b0, 9));
      tbl.push_back(mk(4'h3, 8'd255, 8'd16,  16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 9));
      tbl.push_back(mk(4'h3, 8'd5,   8'd9,   16'h0500, 1'b0, 1'b0, 1'b1, 1'b0, 9));
      tbl.push_back(mk(4'h3, 8'd13,  8'd0,   16'h0DFF, 1'b0, 1'b0, 1'b0, 1'b1, 1));
      tbl.push_back(mk(4'h0, 8'd1,   8'd2,   16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h4, 8'h81,  8'h00,  16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h5, 8'h81,  8'h00,  16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h6, 8'h81,  8'h00,  16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h7, 8'h81,  8'h00,  16'h00C0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h8, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'h9, 8'hF0,  8'h3C,  16'h00FC, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'hA, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'hB, 8'hF0,  8'h3C,  16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'hC, 8'hF0,  8'h3C,  16'h00CF, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'hD, 8'hF0,  8'h3C,  16'h0033, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'hE, 8'd5,   8'd3,   16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'hE, 8'd3,   8'd5,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1));
      tbl.push_back(mk(4'hF, 8'd7,   8'd7,   16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk(4'hF, 8'd7,   8'd8,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1));

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_result", 64'(result), 64'h0);
      check("reset_zero",   64'(zero),   64'h1);
      check("reset_flags",  64'({carry, ovf, dz, busy, done}), 64'h0);
      rst = 1'b1;

      // Table-driven operations
      foreach (tbl[i]) begin
         @(negedge clk);
         run_vec(tbl[i]);
      end

      // Division: busy span, done timing, repeated start ignored
      @(negedge clk);
      op = 4'h3; a = 8'd200; b = 8'd7; start = 1'b1;
      exp_q.push_back(mk(4'h3, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 1'b0, 1'b0, 9));
      @(posedge clk);
      #1 start = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 2) begin op = 4'h0; a = 8'd1; b = 8'd1; start = 1'b1; end
         if (c == 5) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; done_at = c; end
      end
      check("div_busy_cycles", 64'(busy_cnt), 64'd9);
      check("div_done_count",  64'(done_cnt), 64'd1);
      check("div_done_at",     64'(done_at),  64'd9);
      check("div_result_hold", 64'(result),   64'h041C);

      // Reset asserted four cycles into a division
      @(negedge clk);
      op = 4'h3; a = 8'd200; b = 8'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_result", 64'(result), 64'h0);
      check("midrst_zero",   64'(zero),   64'h1);
      check("midrst_flags",  64'({carry, ovf, dz, busy, done}), 64'h0);
      done_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("midrst_no_done", 64'(done_cnt), 64'd0);
      rst = 1'b1;
      // First clock after release must accept the new start
      run_vec(mk(4'h6, 8'h81, 8'h00, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1));

      repeat (12) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 4 bits: opcode, sampled together with start.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: unsigned operands, sampled together with start.
REQ-007 SHALL have port result, output, 2*WIDTH bits: registered result.
REQ-008 SHALL have port carry, output, 1 bit: carry-out, borrow, or shifted-out bit.
REQ-009 SHALL have port ovf, output, 1 bit: overflow flag.
REQ-010 SHALL have port zero, output, 1 bit: set when result[WIDTH-1:0] equals 0.
REQ-011 SHALL have port dz, output, 1 bit: divide-by-zero flag.
REQ-012 SHALL have port busy, output, 1 bit: high when not in IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when result and flags update.

Function
REQ-014 SHALL implement states IDLE, DIV, DONE; IDLE->DONE on start with a non-divide op or with divide and b==0; IDLE->DIV on start with divide and b!=0; DIV->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-015 SHALL latch a, b and op on the clock edge where start=1 in IDLE; start outside IDLE SHALL be ignored and not queued.
REQ-016 SHALL, for every opcode except 3 with b!=0, assert done exactly 1 cycle after the start edge; for opcode 3 with b!=0, WIDTH+1 cycles after.
REQ-017 SHALL update result and flags only in the cycle in which done is high, and hold them until the next done.
REQ-018 SHALL implement opcode 0 ADD: result = zero-extended a+b (WIDTH bits); carry = carry-out; ovf = signed two's-complement overflow.
REQ-019 SHALL implement opcode 1 SUB: result = zero-extended a-b (WIDTH bits); carry = 1 when a<b (borrow); ovf = signed overflow.
REQ-020 SHALL implement opcode 2 MUL: result = full 2*WIDTH product; ovf = 1 when result[2*WIDTH-1:WIDTH]!=0; carry = 0.
REQ-021 SHALL implement opcode 3 DIV with a restoring divider, one quotient bit per cycle: result = {remainder, quotient}.
REQ-022 SHALL, for opcode 3 with b==0: set quotient to all ones, remainder to a, dz=1.
REQ-023 SHALL clear dz on every done except those covered by REQ-022.
REQ-024 SHALL implement opcodes 4 SHL and 5 SHR (logical by 1), with carry = the bit shifted out.
REQ-025 SHALL implement opcodes 6 ROL and 7 ROR (rotate by 1 over WIDTH bits), with carry = 0.
REQ-026 SHALL implement opcodes 8..D as AND, OR, XOR, NOR, NAND, XNOR over WIDTH bits.
REQ-027 SHALL implement opcodes E GT (a>b) and F EQ (a==b), each producing a result of 1 or 0.
REQ-028 SHALL zero-extend result[2*WIDTH-1:WIDTH] for every opcode except MUL and DIV.
REQ-029 SHALL clear ovf for every opcode except ADD, SUB and MUL.
REQ-030 SHALL clear carry for every opcode except ADD, SUB, SHL and SHR.
REQ-031 SHALL keep busy high for the whole operation, from the cycle after the start edge through the DONE cycle.

Reset
REQ-032 SHALL, while rst=0, immediately force: state IDLE; result 0; carry, ovf, dz, busy and done 0; zero 1; latched operands and divider registers 0.
REQ-033 SHALL, on reset asserted mid-division, abandon the operation with no done pulse; start SHALL be accepted in the first clock after rst returns high.

Structure
REQ-034 SHALL place opcode constants (OP_ADD..OP_EQ) and state encodings in a shared package, alu_pkg.
REQ-035 SHALL implement the divider as sub-module alu_div (parameter WIDTH; ports clk, rst, go, dividend, divisor, quotient, remainder, fin).
REQ-036 SHALL keep all other operations as combinational logic feeding the result register.

Verification (WIDTH=8)
REQ-037 SHALL cover ADD: op=0, a=200, b=100 -> result=0x002C, carry=1, ovf=0, zero=0, done 1 cycle after start.
REQ-038 SHALL cover SUB borrow: op=1, a=3, b=5 -> result=0x00FE, carry=1; SUB equal: a=b=9 -> result=0, zero=1.
REQ-039 SHALL cover MUL: op=2, 15*17 -> 0x00FF, ovf=0; 16*16 -> 0x0100, ovf=1.
REQ-040 SHALL cover DIV: op=3, a=200, b=7 -> result=0x041C, busy high for 9 cycles, done 9 cycles after start; repeated start during DIV ignored.
REQ-041 SHALL cover divide-by-zero: op=3, a=13, b=0 -> result=0x0DFF, dz=1, done 1 cycle after start; next ADD clears dz.
REQ-042 SHALL cover reset mid-operation: rst=0 asserted 4 cycles into a DIV -> all outputs at reset values asynchronously, no done pulse; ROL of a=0x81 after release -> 0x0003.
